// File: rtl/button_pkg.sv
// button_pkg: shared state encoding and limits for the button conditioner
package button_pkg;
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;
  localparam logic [7:0] REJECT_MAX = 8'd255;
  localparam int DEBOUNCE_DEFAULT = 4;
endpackage

// File: rtl/bit_sync.sv
// bit_sync: parameterised flop chain bringing an async bit into the clk domain
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sr;
  always_ff @(posedge clk) sr <= rst ? '0 : {sr[STAGES-2:0], d};
  assign q = sr[STAGES-1];
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: synchronise, debounce and edge-detect a raw push-button
module button_conditioner
  import button_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button_raw,
  output logic       button_db,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [7:0] reject_cnt
);
  logic btn_s, done, reject;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  bit_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(button_raw), .q(btn_s));
  assign done = cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
  // a toggle on the final counted sample is checked first, so it aborts the wait
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    reject = 1'b0;
    case (state)
      IDLE:
        if (btn_s) begin
          state_nx = PRESS_WAIT;
          cnt_nx = CNT_W'(1);
        end
      PRESS_WAIT:
        if (!btn_s) begin
          state_nx = IDLE;
          reject = 1'b1;
        end else if (done) state_nx = PRESSED;
        else cnt_nx = cnt + CNT_W'(1);
      PRESSED:
        if (!btn_s) begin
          state_nx = RELEASE_WAIT;
          cnt_nx = CNT_W'(1);
        end
      RELEASE_WAIT:
        if (btn_s) begin
          state_nx = PRESSED;
          reject = 1'b1;
        end else if (done) state_nx = IDLE;
        else cnt_nx = cnt + CNT_W'(1);
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      button_db <= 1'b0;
      press_pulse <= 1'b0;
      release_pulse <= 1'b0;
      reject_cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      button_db <= state_nx inside {PRESSED, RELEASE_WAIT};
      press_pulse <= state == PRESS_WAIT && state_nx == PRESSED;
      release_pulse <= state == RELEASE_WAIT && state_nx == IDLE;
      if (reject && reject_cnt != REJECT_MAX) reject_cnt <= reject_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed and random stimulus against a run-length debounce model
module tb_button_conditioner;
  localparam int SYNC = 2;
  localparam int DEB = 4;
  logic clk = 1'b0, rst = 1'b1, button_raw = 1'b0;
  logic button_db, press_pulse, release_pulse;
  logic [7:0] reject_cnt;
  int total = 0, bad = 0;
  bit chk_en = 1'b0;
  logic m_sync [SYNC];
  logic m_db = 1'b0, m_press = 1'b0, m_rel = 1'b0;
  int m_pend = 0, m_rej = 0;

  button_conditioner #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .button_raw(button_raw), .button_db(button_db),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .reject_cnt(reject_cnt)
  );

  always #10 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // model: the accepted level flips once DEB consecutive synchronised samples disagree with it
  task automatic step(input logic r, input logic b);
    logic s;
    @(negedge clk);
    rst = r;
    button_raw = b;
    @(posedge clk);
    m_press = 1'b0;
    m_rel = 1'b0;
    if (r) begin
      foreach (m_sync[i]) m_sync[i] = 1'b0;
      m_db = 1'b0;
      m_pend = 0;
      m_rej = 0;
    end else begin
      s = m_sync[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = b;
      if (s != m_db) begin
        m_pend++;
        if (m_pend == DEB) begin
          m_db = s;
          m_pend = 0;
          m_press = s;
          m_rel = !s;
        end
      end else begin
        if (m_pend > 0 && m_rej < 255) m_rej++;
        m_pend = 0;
      end
    end
  endtask

  task automatic run(input logic r, input logic b, input int n);
    repeat (n) step(r, b);
  endtask

  task automatic edges_until(input logic b, input logic lvl, output int n);
    n = -1;
    for (int i = 0; i < 50; i++) begin
      step(1'b0, b);
      #1;
      if (button_db === lvl) begin
        n = i + 1;
        break;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_db", button_db, m_db);
      chk("model_press", press_pulse, m_press);
      chk("model_release", release_pulse, m_rel);
      chk("model_reject", reject_cnt, m_rej);
    end
  end

  initial begin
    int n;
    logic lvl;
    foreach (m_sync[i]) m_sync[i] = 1'b0;
    run(1'b1, 1'b1, 2);
    chk_en = 1'b1;
    #1;
    chk("rst_db", button_db, 0);
    chk("rst_press", press_pulse, 0);
    chk("rst_release", release_pulse, 0);
    chk("rst_reject", reject_cnt, 0);
    edges_until(1'b1, 1'b1, n);
    chk("held_through_rst_latency", n, 6);
    chk("held_through_rst_press", press_pulse, 1);
    step(1'b0, 1'b1);
    #1;
    chk("press_one_cycle", press_pulse, 0);
    edges_until(1'b0, 1'b0, n);
    chk("release_latency", n, 6);
    chk("release_pulse", release_pulse, 1);
    run(1'b0, 1'b0, 3);
    edges_until(1'b1, 1'b1, n);
    chk("clean_press_latency", n, 6);
    chk("clean_press_pulse", press_pulse, 1);
    chk("clean_press_reject", reject_cnt, 0);
    run(1'b0, 1'b1, 10);
    edges_until(1'b0, 1'b0, n);
    chk("clean_release_latency", n, 6);
    run(1'b0, 1'b0, 5);
    run(1'b0, 1'b1, 2);
    run(1'b0, 1'b0, 8);
    #1;
    chk("bounce_db", button_db, 0);
    chk("bounce_reject", reject_cnt, 1);
    edges_until(1'b1, 1'b1, n);
    chk("press_before_release_bounce", n, 6);
    run(1'b0, 1'b1, 3);
    step(1'b0, 1'b0);
    run(1'b0, 1'b1, 6);
    edges_until(1'b0, 1'b0, n);
    chk("bounced_release_latency", n, 6);
    chk("bounced_release_pulse", release_pulse, 1);
    chk("bounced_release_reject", reject_cnt, 2);
    run(1'b0, 1'b0, 4);
    repeat (300) begin
      run(1'b0, 1'b1, 2);
      run(1'b0, 1'b0, 2);
    end
    #1;
    chk("saturated_reject", reject_cnt, 255);
    run(1'b0, 1'b1, 2);
    run(1'b0, 1'b0, 4);
    #1;
    chk("saturated_hold", reject_cnt, 255);
    edges_until(1'b1, 1'b1, n);
    chk("press_before_mid_rst", n, 6);
    run(1'b0, 1'b1, 3);
    step(1'b1, 1'b1);
    #1;
    chk("mid_rst_db", button_db, 0);
    chk("mid_rst_release", release_pulse, 0);
    chk("mid_rst_reject", reject_cnt, 0);
    run(1'b0, 1'b0, 4);
    lvl = 1'b0;
    repeat (300) begin
      lvl = $urandom_range(0, 3) == 0 ? lvl : !lvl;
      if ($urandom_range(0, 99) == 0) step(1'b1, lvl);
      run(1'b0, lvl, $urandom_range(1, 8));
    end
    run(1'b0, 1'b0, 10);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
